mtr_drv_sched: RTL and testbench
================================

// Module: mtr_drv_sched
// PURPOSE
//  Sequences duty updates for the left/right PWM11 motor generators of the Segway drive.
//  - Takes signed speed commands and converts them to magnitude + direction.
//  - Commits new duty only at the PWM period boundary (PWM_synch), so periods are never torn.
//  - Inserts a zero-duty dead period on direction reversal.
//  - Runs the over-current shutdown FSM from the blanked OVR_I inputs.
// PARAMETERS
//  SPD_W     12     width of signed speed commands
//  DUTY_W    11     duty width; matches the PWM11 counter
//  MIN_DUTY  11'h080  offset added to any nonzero magnitude (overcomes motor stiction)
//  OVR_LIMIT 4      consecutive faulty PWM periods that trip shutdown (range 1..15)
// PORTS
//  clk            in   1       system clock
//  rst            in   1       asynchronous, active-high reset
//  lft_spd        in   SPD_W   signed left speed command
//  rght_spd       in   SPD_W   signed right speed command
//  spd_vld        in   1       1-cycle strobe: capture lft_spd/rght_spd into pending regs
//  PWM_synch      in   1       1-cycle pulse at PWM counter terminal count (period boundary)
//  OVR_I_blank_n  in   1       high = outside switching blank window; OVR_I is trusted
//  OVR_I_lft      in   1       left bridge over-current comparator
//  OVR_I_rght     in   1       right bridge over-current comparator
//  clr_fault      in   1       level: release FAULT state
//  lft_duty       out  DUTY_W  duty to left PWM11
//  rght_duty      out  DUTY_W  duty to right PWM11
//  lft_rev        out  1       left direction, 1 = reverse
//  rght_rev       out  1       right direction, 1 = reverse
//  drv_en         out  1       H-bridge enable
//  OVR_I_shtdwn   out  1       high while in FAULT
// BEHAVIOUR
//  Reset
//   - All outputs 0, pending regs 0, pend flag 0, ovr_cnt 0, state IDLE.
//   - Takes effect immediately, including mid-period and in FAULT.
//  Capture
//   - spd_vld high: load pending regs, set pend.
//   - A later spd_vld before commit overwrites the pending regs.
//  Conversion (per side, from the pending value)
//   - rev = spd[SPD_W-1].
//   - mag = |spd|; -2048 saturates to 2047.
//   - duty = 0 if mag==0, else min(MIN_DUTY+mag, 2047); add is 12-bit, then saturated.
//  Commit
//   - Occurs only on a clk edge where PWM_synch==1.
//   - Outputs are visible the cycle after PWM_synch.
//   - Commit clears pend.
//   - spd_vld coincident with PWM_synch: the commit uses the old pending contents; the new value stays pending for the next boundary.
//  FSM
//   - IDLE: on PWM_synch -> RUN; drv_en=1; commit if pend.
//   - RUN: on PWM_synch with pend:
//     - If either side's rev differs from its current output while that side's current duty != 0 -> DEAD. Both duties are forced 0 for one period; directions are held.
//     - Otherwise commit.
//   - DEAD: on next PWM_synch, commit the pending values (including any updated during DEAD) -> RUN.
//   - FAULT: duties 0, rev held, drv_en=0, OVR_I_shtdwn=1.
//     - With clr_fault high, the next PWM_synch -> RUN, ovr_cnt=0, drv_en=1.
//     - Duty commits from pend if set, else stays 0.
//  Over-current
//   - Sticky flag set when (OVR_I_lft|OVR_I_rght) & OVR_I_blank_n in any cycle of a period.
//   - At PWM_synch: flag set -> ovr_cnt+1 (saturating); else ovr_cnt=0. Flag cleared every PWM_synch.
//   - ovr_cnt reaching OVR_LIMIT at that edge -> FAULT from any state.
//   - FAULT takes priority over commit and DEAD at the same edge.
//   - OVR_I with OVR_I_blank_n==0 is ignored.
//   - OVR_I is not monitored in FAULT.
// TESTING
//  1. Reset, then PWM_synch: drv_en=1, duties 0. spd_vld lft=+100, rght=-100, then PWM_synch -> lft_duty=rght_duty=0x0E4, lft_rev=0, rght_rev=1 one cycle later.
//  2. lft=+2047 and -2048 -> duty 2047 (saturation). lft=0 -> duty 0 (no offset).
//  3. Running lft=+200, then spd_vld lft=-200 -> one full period with both duties 0 (DEAD), then lft_duty=0x148, lft_rev=1.
//  4. spd_vld and PWM_synch in the same cycle -> old pending commits; new value commits at the following PWM_synch.
//  5. OVR_I_lft high inside blank window (OVR_I_blank_n=0) for 10 periods -> no fault.
//     OVR_I high unblanked in 4 consecutive periods -> OVR_I_shtdwn=1, drv_en=0, duties 0.
//     3 faulty periods + 1 clean period + 3 faulty periods -> no fault.
//  6. In FAULT, clr_fault high then PWM_synch -> RUN, drv_en=1.
//     Assert rst mid-period in RUN -> all outputs 0 immediately.

Source files
------------

// File: rtl/mtr_drv_sched.sv
// Duty sequencer for the left/right PWM11 motor generators: signed speed to duty/direction,
// period-aligned commits, a zero-duty dead period on reversal, and over-current shutdown.
module mtr_drv_sched #(
  parameter int                SPD_W     = 12,
  parameter int                DUTY_W    = 11,
  parameter logic [DUTY_W-1:0] MIN_DUTY  = 11'h080,
  parameter int                OVR_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SPD_W-1:0]  lft_spd,
  input  logic [SPD_W-1:0]  rght_spd,
  input  logic              spd_vld,
  input  logic              PWM_synch,
  input  logic              OVR_I_blank_n,
  input  logic              OVR_I_lft,
  input  logic              OVR_I_rght,
  input  logic              clr_fault,
  output logic [DUTY_W-1:0] lft_duty,
  output logic [DUTY_W-1:0] rght_duty,
  output logic              lft_rev,
  output logic              rght_rev,
  output logic              drv_en,
  output logic              OVR_I_shtdwn
);

  localparam int SUM_W = ((SPD_W > DUTY_W) ? SPD_W : DUTY_W) + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DEAD  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  localparam logic [DUTY_W-1:0] DUTY_ZERO   = {DUTY_W{1'b0}};
  localparam logic [DUTY_W-1:0] DUTY_MAX    = {DUTY_W{1'b1}};
  localparam logic [3:0]        OVR_LIM_C   = 4'(OVR_LIMIT);
  localparam logic [3:0]        OVR_CNT_MAX = 4'hF;

  // Magnitude plus stiction offset, saturated; the most negative command saturates like the most positive.
  function automatic logic [DUTY_W-1:0] spd2duty(input logic [SPD_W-1:0] spd);
    logic [SPD_W-1:0] neg_v;
    logic [SPD_W-1:0] mag_v;
    logic [SUM_W-1:0] sum_v;
    neg_v = (~spd) + {{(SPD_W-1){1'b0}}, 1'b1};
    if (spd[SPD_W-1]) begin
      if (neg_v[SPD_W-1]) begin
        mag_v = {1'b0, {(SPD_W-1){1'b1}}};
      end else begin
        mag_v = neg_v;
      end
    end else begin
      mag_v = spd;
    end
    sum_v = SUM_W'(mag_v) + SUM_W'(MIN_DUTY);
    if (mag_v == {SPD_W{1'b0}}) begin
      return DUTY_ZERO;
    end else if (sum_v > SUM_W'(DUTY_MAX)) begin
      return DUTY_MAX;
    end else begin
      return sum_v[DUTY_W-1:0];
    end
  endfunction

  logic [1:0]        state_r, state_s;
  logic              pend_r, pend_s;
  logic [SPD_W-1:0]  pend_lft_r, pend_rght_r;
  logic              ovr_flag_r, ovr_flag_s;
  logic [3:0]        ovr_cnt_r, ovr_cnt_s;
  logic [3:0]        ovr_cnt_inc_s;
  logic              ovr_hit_s, ovr_seen_s, trip_s, reverse_s, commit_s;
  logic [DUTY_W-1:0] lft_cmd_duty_s, rght_cmd_duty_s;
  logic              lft_cmd_rev_s, rght_cmd_rev_s;
  logic [DUTY_W-1:0] lft_duty_s, rght_duty_s;
  logic              lft_rev_s, rght_rev_s, drv_en_s, shtdwn_s;

  assign lft_cmd_duty_s  = spd2duty(pend_lft_r);
  assign rght_cmd_duty_s = spd2duty(pend_rght_r);
  assign lft_cmd_rev_s   = pend_lft_r[SPD_W-1];
  assign rght_cmd_rev_s  = pend_rght_r[SPD_W-1];

  // A blanked comparator is switching noise; only unblanked hits count toward the period flag.
  assign ovr_hit_s     = (OVR_I_lft | OVR_I_rght) & OVR_I_blank_n;
  assign ovr_seen_s    = ovr_flag_r | ovr_hit_s;
  assign ovr_cnt_inc_s = (ovr_cnt_r == OVR_CNT_MAX) ? OVR_CNT_MAX : (ovr_cnt_r + 4'd1);
  assign trip_s        = PWM_synch & (state_r != ST_FAULT) & ovr_seen_s & (ovr_cnt_inc_s >= OVR_LIM_C);
  assign reverse_s     = ((lft_cmd_rev_s != lft_rev) & (lft_duty != DUTY_ZERO)) |
                         ((rght_cmd_rev_s != rght_rev) & (rght_duty != DUTY_ZERO));

  // Period-boundary sequencing: fault detection, dead-period insertion and duty commit.
  always_comb begin
    state_s     = state_r;
    ovr_flag_s  = ovr_flag_r;
    ovr_cnt_s   = ovr_cnt_r;
    commit_s    = 1'b0;
    lft_duty_s  = lft_duty;
    rght_duty_s = rght_duty;
    lft_rev_s   = lft_rev;
    rght_rev_s  = rght_rev;
    drv_en_s    = drv_en;
    shtdwn_s    = OVR_I_shtdwn;
    if (PWM_synch) begin
      ovr_flag_s = 1'b0;
      if (state_r != ST_FAULT) begin
        ovr_cnt_s = ovr_seen_s ? ovr_cnt_inc_s : 4'd0;
      end else begin
        ovr_cnt_s = ovr_cnt_r;
      end
      if (trip_s) begin
        state_s     = ST_FAULT;
        lft_duty_s  = DUTY_ZERO;
        rght_duty_s = DUTY_ZERO;
        drv_en_s    = 1'b0;
        shtdwn_s    = 1'b1;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_s  = ST_RUN;
            drv_en_s = 1'b1;
            commit_s = pend_r;
          end
          ST_RUN: begin
            if (pend_r && reverse_s) begin
              state_s     = ST_DEAD;
              lft_duty_s  = DUTY_ZERO;
              rght_duty_s = DUTY_ZERO;
            end else begin
              commit_s = pend_r;
            end
          end
          ST_DEAD: begin
            state_s  = ST_RUN;
            commit_s = 1'b1;
          end
          ST_FAULT: begin
            if (clr_fault) begin
              state_s   = ST_RUN;
              drv_en_s  = 1'b1;
              shtdwn_s  = 1'b0;
              ovr_cnt_s = 4'd0;
              commit_s  = pend_r;
            end else begin
              state_s = ST_FAULT;
            end
          end
          default: begin
            state_s     = ST_IDLE;
            lft_duty_s  = DUTY_ZERO;
            rght_duty_s = DUTY_ZERO;
            drv_en_s    = 1'b0;
            shtdwn_s    = 1'b0;
          end
        endcase
      end
    end else begin
      if (state_r != ST_FAULT) begin
        ovr_flag_s = ovr_seen_s;
      end else begin
        ovr_flag_s = 1'b0;
      end
    end
    if (commit_s) begin
      lft_duty_s  = lft_cmd_duty_s;
      rght_duty_s = rght_cmd_duty_s;
      lft_rev_s   = lft_cmd_rev_s;
      rght_rev_s  = rght_cmd_rev_s;
    end else begin
      commit_s = 1'b0;
    end
    // A strobe coincident with a commit re-arms pend for the next boundary.
    if (spd_vld) begin
      pend_s = 1'b1;
    end else if (commit_s) begin
      pend_s = 1'b0;
    end else begin
      pend_s = pend_r;
    end
  end

  // Pending speed command registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_lft_r  <= {SPD_W{1'b0}};
      pend_rght_r <= {SPD_W{1'b0}};
    end else if (spd_vld) begin
      pend_lft_r  <= lft_spd;
      pend_rght_r <= rght_spd;
    end else begin
      pend_lft_r  <= pend_lft_r;
      pend_rght_r <= pend_rght_r;
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      pend_r       <= 1'b0;
      ovr_flag_r   <= 1'b0;
      ovr_cnt_r    <= 4'd0;
      lft_duty     <= DUTY_ZERO;
      rght_duty    <= DUTY_ZERO;
      lft_rev      <= 1'b0;
      rght_rev     <= 1'b0;
      drv_en       <= 1'b0;
      OVR_I_shtdwn <= 1'b0;
    end else begin
      state_r      <= state_s;
      pend_r       <= pend_s;
      ovr_flag_r   <= ovr_flag_s;
      ovr_cnt_r    <= ovr_cnt_s;
      lft_duty     <= lft_duty_s;
      rght_duty    <= rght_duty_s;
      lft_rev      <= lft_rev_s;
      rght_rev     <= rght_rev_s;
      drv_en       <= drv_en_s;
      OVR_I_shtdwn <= shtdwn_s;
    end
  end

endmodule

// File: tb/tb_mtr_drv_sched.sv
// Self-checking bench for mtr_drv_sched: directed scenarios plus randomized traffic
// compared against a behavioural model built from the duty/dead-period/fault rules.
module tb_mtr_drv_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] lft_spd = 12'd0;
  logic [11:0] rght_spd = 12'd0;
  logic        spd_vld = 1'b0;
  logic        PWM_synch = 1'b0;
  logic        OVR_I_blank_n = 1'b1;
  logic        OVR_I_lft = 1'b0;
  logic        OVR_I_rght = 1'b0;
  logic        clr_fault = 1'b0;
  logic [10:0] lft_duty, rght_duty;
  logic        lft_rev, rght_rev, drv_en, OVR_I_shtdwn;

  int checks = 0;
  int errors = 0;

  mtr_drv_sched dut (
    .clk(clk), .rst(rst), .lft_spd(lft_spd), .rght_spd(rght_spd), .spd_vld(spd_vld),
    .PWM_synch(PWM_synch), .OVR_I_blank_n(OVR_I_blank_n), .OVR_I_lft(OVR_I_lft),
    .OVR_I_rght(OVR_I_rght), .clr_fault(clr_fault), .lft_duty(lft_duty), .rght_duty(rght_duty),
    .lft_rev(lft_rev), .rght_rev(rght_rev), .drv_en(drv_en), .OVR_I_shtdwn(OVR_I_shtdwn)
  );

  always #5 clk = ~clk;

  // Behavioural model
  localparam int M_IDLE = 0, M_RUN = 1, M_DEAD = 2, M_FAULT = 3;
  int m_state, m_pl, m_pr, m_cnt, m_ld, m_rd;
  bit m_pend, m_flag, m_lr, m_rr, m_en, m_sh;

  function automatic int duty_of(int s);
    int mag;
    mag = (s < 0) ? -s : s;
    if (mag > 2047) mag = 2047;
    if (mag == 0) return 0;
    return (mag + 128 > 2047) ? 2047 : mag + 128;
  endfunction

  task automatic m_reset();
    m_state = M_IDLE; m_pl = 0; m_pr = 0; m_cnt = 0; m_ld = 0; m_rd = 0;
    m_pend = 0; m_flag = 0; m_lr = 0; m_rr = 0; m_en = 0; m_sh = 0;
  endtask

  task automatic m_commit();
    m_ld = duty_of(m_pl); m_rd = duty_of(m_pr);
    m_lr = (m_pl < 0); m_rr = (m_pr < 0); m_pend = 0;
  endtask

  task automatic model_step();
    bit hit, trip;
    if (rst) begin
      m_reset();
      return;
    end
    hit = (OVR_I_lft || OVR_I_rght) && OVR_I_blank_n;
    if (PWM_synch) begin
      trip = 0;
      if (m_state != M_FAULT) begin
        m_cnt = (m_flag || hit) ? ((m_cnt < 15) ? m_cnt + 1 : 15) : 0;
        trip = (m_cnt >= 4);
      end
      m_flag = 0;
      if (trip) begin
        m_state = M_FAULT; m_ld = 0; m_rd = 0; m_en = 0; m_sh = 1;
      end else if (m_state == M_IDLE) begin
        m_state = M_RUN; m_en = 1;
        if (m_pend) m_commit();
      end else if (m_state == M_RUN) begin
        if (m_pend) begin
          if (((m_pl < 0) != m_lr && m_ld != 0) || ((m_pr < 0) != m_rr && m_rd != 0)) begin
            m_state = M_DEAD; m_ld = 0; m_rd = 0;
          end else begin
            m_commit();
          end
        end
      end else if (m_state == M_DEAD) begin
        m_commit(); m_state = M_RUN;
      end else if (clr_fault) begin
        m_state = M_RUN; m_en = 1; m_sh = 0; m_cnt = 0;
        if (m_pend) m_commit();
      end
    end else if (m_state != M_FAULT) begin
      m_flag = m_flag || hit;
    end
    if (spd_vld) begin
      m_pl = $signed(lft_spd); m_pr = $signed(rght_spd); m_pend = 1;
    end
  endtask

  function automatic logic [25:0] dut_vec();
    return {lft_duty, rght_duty, lft_rev, rght_rev, drv_en, OVR_I_shtdwn};
  endfunction

  function automatic logic [25:0] exp_vec();
    return {11'(m_ld), 11'(m_rd), m_lr, m_rr, m_en, m_sh};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int l, input int r);
    lft_spd = 12'(l); rght_spd = 12'(r); spd_vld = 1'b1;
    tick();
    spd_vld = 1'b0;
  endtask

  task automatic boundary();
    repeat (7) tick();
    PWM_synch = 1'b1;
    tick();
    PWM_synch = 1'b0;
  endtask

  task automatic faulty_period();
    repeat (3) tick();
    OVR_I_rght = 1'b1;
    tick();
    OVR_I_rght = 1'b0;
    repeat (3) tick();
    PWM_synch = 1'b1;
    tick();
    PWM_synch = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if (dut_vec() !== 26'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected %h", dut_vec(), 26'd0);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    boundary();
    checks++;
    if (dut_vec() !== {11'h000, 11'h000, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL idle_to_run: got %h", dut_vec());
    end
    send(100, -100);
    repeat (6) tick();
    checks++;
    if (lft_duty !== 11'h000) begin
      errors++; $display("FAIL no_early_commit: got %h expected 000", lft_duty);
    end
    PWM_synch = 1'b1; tick(); PWM_synch = 1'b0;
    checks++;
    if (dut_vec() !== {11'h0E4, 11'h0E4, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL basic_commit: got %h", dut_vec());
    end
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL basic_model: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_saturation();
    send(2047, -2048); boundary();
    checks++;
    if ({lft_duty, rght_duty} !== {11'h7FF, 11'h7FF}) begin
      errors++; $display("FAIL sat_pos_neg: got %h %h expected 7ff 7ff", lft_duty, rght_duty);
    end
    send(0, -2048); boundary();
    checks++;
    if ({lft_duty, lft_rev} !== {11'h000, 1'b0}) begin
      errors++; $display("FAIL zero_no_offset: got %h/%b expected 000/0", lft_duty, lft_rev);
    end
    send(-2048, -1); boundary();
    checks++;
    if ({lft_duty, lft_rev, rght_duty, rght_rev} !== {11'h7FF, 1'b1, 11'h081, 1'b1}) begin
      errors++; $display("FAIL sat_min: got %h/%b %h/%b", lft_duty, lft_rev, rght_duty, rght_rev);
    end
  endtask

  task automatic test_dead();
    send(0, 0); boundary(); boundary();
    send(200, 0); boundary();
    checks++;
    if ({lft_duty, lft_rev} !== {11'h148, 1'b0}) begin
      errors++; $display("FAIL dead_setup: got %h/%b expected 148/0", lft_duty, lft_rev);
    end
    send(-200, 0); boundary();
    checks++;
    if ({lft_duty, rght_duty, lft_rev} !== {11'h000, 11'h000, 1'b0}) begin
      errors++; $display("FAIL dead_zero: got %h %h %b", lft_duty, rght_duty, lft_rev);
    end
    repeat (7) tick();
    checks++;
    if ({lft_duty, lft_rev} !== {11'h000, 1'b0}) begin
      errors++; $display("FAIL dead_full_period: got %h/%b expected 000/0", lft_duty, lft_rev);
    end
    PWM_synch = 1'b1; tick(); PWM_synch = 1'b0;
    checks++;
    if ({lft_duty, lft_rev} !== {11'h148, 1'b1}) begin
      errors++; $display("FAIL dead_exit: got %h/%b expected 148/1", lft_duty, lft_rev);
    end
  endtask

  task automatic test_same_cycle();
    send(-300, 0);
    repeat (6) tick();
    lft_spd = 12'(-400); spd_vld = 1'b1; PWM_synch = 1'b1;
    tick();
    spd_vld = 1'b0; PWM_synch = 1'b0;
    checks++;
    if (lft_duty !== 11'h1AC) begin
      errors++; $display("FAIL coincident_old: got %h expected 1ac", lft_duty);
    end
    boundary();
    checks++;
    if (lft_duty !== 11'h210) begin
      errors++; $display("FAIL coincident_new: got %h expected 210", lft_duty);
    end
  endtask

  task automatic test_ovr();
    OVR_I_lft = 1'b1; OVR_I_blank_n = 1'b0;
    repeat (10) boundary();
    OVR_I_lft = 1'b0; OVR_I_blank_n = 1'b1;
    checks++;
    if ({drv_en, OVR_I_shtdwn} !== 2'b10) begin
      errors++; $display("FAIL blank_ignored: got %b expected 10", {drv_en, OVR_I_shtdwn});
    end
    repeat (3) faulty_period();
    boundary();
    repeat (3) faulty_period();
    checks++;
    if ({drv_en, OVR_I_shtdwn} !== 2'b10) begin
      errors++; $display("FAIL ovr_nonconsecutive: got %b expected 10", {drv_en, OVR_I_shtdwn});
    end
    boundary();
    repeat (3) faulty_period();
    checks++;
    if (OVR_I_shtdwn !== 1'b0) begin
      errors++; $display("FAIL ovr_three: got %b expected 0", OVR_I_shtdwn);
    end
    faulty_period();
    checks++;
    if ({lft_duty, rght_duty, lft_rev, drv_en, OVR_I_shtdwn} !== {11'h000, 11'h000, 1'b1, 1'b0, 1'b1}) begin
      errors++; $display("FAIL ovr_trip: got %h %h rev=%b en=%b sh=%b", lft_duty, rght_duty, lft_rev, drv_en, OVR_I_shtdwn);
    end
  endtask

  task automatic test_clear();
    send(100, 100);
    faulty_period(); faulty_period(); boundary();
    checks++;
    if ({lft_duty, drv_en, OVR_I_shtdwn} !== {11'h000, 1'b0, 1'b1}) begin
      errors++; $display("FAIL fault_hold: got %h en=%b sh=%b", lft_duty, drv_en, OVR_I_shtdwn);
    end
    clr_fault = 1'b1; boundary(); clr_fault = 1'b0;
    checks++;
    if (dut_vec() !== {11'h0E4, 11'h0E4, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL fault_clear: got %h", dut_vec());
    end
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL fault_clear_model: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (dut_vec() !== 26'd0) begin
      errors++; $display("FAIL async_reset: got %h expected 0", dut_vec());
    end
    m_reset();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL post_reset_model: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    int per_left;
    per_left = 6;
    for (int i = 0; i < 3000; i++) begin
      spd_vld = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 9) == 0) begin
        lft_spd = ($urandom_range(0, 1) == 1) ? 12'h800 : 12'h7FF;
      end else begin
        lft_spd = 12'(int'($urandom_range(0, 600)) - 300);
      end
      rght_spd = 12'(int'($urandom_range(0, 4095)) - 2048);
      OVR_I_lft = ($urandom_range(0, 9) == 0);
      OVR_I_rght = ($urandom_range(0, 29) == 0);
      OVR_I_blank_n = ($urandom_range(0, 1) == 1);
      PWM_synch = (per_left == 0);
      if (per_left == 0) begin
        per_left = $urandom_range(4, 10);
        clr_fault = ($urandom_range(0, 2) == 0);
      end else begin
        per_left--;
      end
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
    spd_vld = 1'b0; PWM_synch = 1'b0; OVR_I_lft = 1'b0; OVR_I_rght = 1'b0;
    OVR_I_blank_n = 1'b1; clr_fault = 1'b0;
  endtask

  initial begin
    m_reset();
    test_reset();
    test_basic();
    test_saturation();
    test_dead();
    test_same_cycle();
    test_ovr();
    test_clear();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
